// File: rtl/vu_pkg.sv
// vu_pkg: shared VU meter types, level-width helper and thermometer decode
package vu_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, HOLD = 2'd1, FALL = 2'd2} peak_state_t;
  function automatic int lvl_w(input int leds);
    return $clog2(leds + 1);
  endfunction
  function automatic logic [63:0] thermo(input int unsigned n);
    return n >= 64 ? '1 : (64'd1 << n) - 64'd1;
  endfunction
endpackage

// File: rtl/vu_mag_quant.sv
// vu_mag_quant: sample magnitude with saturation, quantised to a bar level and registered
module vu_mag_quant
  import vu_pkg::*;
#(
  parameter int SAMPLE_W = 8,
  parameter int LEDS = 8,
  localparam int LVL_W = lvl_w(LEDS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] sample,
  output logic                valid_q,
  output logic [LVL_W-1:0]    lvl_in
);
  localparam int SH = SAMPLE_W - 1 - $clog2(LEDS);
  localparam logic [LVL_W-1:0] MAX = LVL_W'(LEDS);
  logic [SAMPLE_W-1:0] neg;
  logic [SAMPLE_W-2:0] mag;
  logic [SAMPLE_W+LVL_W-2:0] shf;
  logic [LVL_W-1:0] q, lvl;
  always_comb begin
    neg = -sample;
    mag = sample == {1'b1, {(SAMPLE_W-1){1'b0}}} ? '1 :
          sample[SAMPLE_W-1] ? neg[SAMPLE_W-2:0] : sample[SAMPLE_W-2:0];
    shf = {{LVL_W{1'b0}}, mag} >> SH;
    q = shf[LVL_W-1:0] + 1'b1;
    lvl = mag == '0 ? '0 : q > MAX ? MAX : q;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      valid_q <= 1'b0;
      lvl_in <= '0;
    end else begin
      valid_q <= sample_valid;
      lvl_in <= sample_valid ? lvl : '0;
    end
endmodule

// File: rtl/vu_bar_driver.sv
// vu_bar_driver: LED bar with instant attack, tick-paced decay and a hold/fall peak dot
module vu_bar_driver
  import vu_pkg::*;
#(
  parameter int SAMPLE_W = 8,
  parameter int LEDS = 8,
  parameter int HOLD_TICKS = 16,
  parameter int DECAY_TICKS = 4,
  localparam int LVL_W = lvl_w(LEDS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] sample,
  input  logic                tick,
  output logic [LEDS-1:0]     bar,
  output logic [LVL_W-1:0]    bar_lvl,
  output logic [LVL_W-1:0]    peak_lvl,
  output logic [1:0]          peak_state
);
  localparam int DW = DECAY_TICKS > 1 ? $clog2(DECAY_TICKS) : 1;
  localparam int HW = HOLD_TICKS > 1 ? $clog2(HOLD_TICKS) : 1;
  logic valid_q;
  logic [LVL_W-1:0] lvl_in, bar_n, pk_n;
  logic [DW-1:0] dec_cnt, dec_n;
  logic [HW-1:0] hold_cnt, hc_n;
  peak_state_t st, st_n;
  logic dec_wrap, pk_att;
  logic [63:0] th;
  logic [LEDS-1:0] oh;
  vu_mag_quant #(.SAMPLE_W(SAMPLE_W), .LEDS(LEDS)) u_quant (
    .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample(sample),
    .valid_q(valid_q), .lvl_in(lvl_in)
  );
  always_comb begin
    dec_wrap = tick && dec_cnt == DW'(DECAY_TICKS - 1);
    dec_n = tick ? (dec_wrap ? '0 : dec_cnt + 1'b1) : dec_cnt;
    bar_n = valid_q && lvl_in > bar_lvl ? lvl_in :
            dec_wrap && bar_lvl != '0 ? bar_lvl - 1'b1 : bar_lvl;
    pk_att = valid_q && lvl_in != '0 && lvl_in >= peak_lvl;
    st_n = st;
    pk_n = peak_lvl;
    hc_n = hold_cnt;
    // attack wins over a same-cycle tick, which is then not counted
    if (pk_att) begin
      st_n = HOLD;
      pk_n = lvl_in;
      hc_n = '0;
    end else if (tick && st == HOLD) begin
      hc_n = hold_cnt == HW'(HOLD_TICKS - 1) ? '0 : hold_cnt + 1'b1;
      st_n = hold_cnt == HW'(HOLD_TICKS - 1) ? FALL : HOLD;
    end else if (tick && st == FALL) begin
      pk_n = peak_lvl - 1'b1;
      st_n = peak_lvl == LVL_W'(1) ? IDLE : FALL;
    end
    th = thermo(32'(bar_lvl));
    oh = peak_lvl != '0 ? {{(LEDS-1){1'b0}}, 1'b1} << (peak_lvl - 1'b1) : '0;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      bar <= '0;
      bar_lvl <= '0;
      peak_lvl <= '0;
      st <= IDLE;
      dec_cnt <= '0;
      hold_cnt <= '0;
    end else begin
      bar <= th[LEDS-1:0] | oh;
      bar_lvl <= bar_n;
      peak_lvl <= pk_n;
      st <= st_n;
      dec_cnt <= dec_n;
      hold_cnt <= hc_n;
    end
  assign peak_state = st;
endmodule
